// File: rtl/foc_axis_block_detector.sv
// rtl/foc_axis_block_detector.sv - per-channel AXI-Stream stall detector feeding the dataflow deadlock monitors
module foc_axis_block_detector #(
    parameter int                NUM_CH   = 10,
    parameter int                IDX_W    = 4,
    parameter int                CNT_W    = 16,
    parameter int                THRESH   = 1024,
    parameter logic [NUM_CH-1:0] DIR_MASK = 10'h000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              clear,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              any_block,
    output logic              first_valid,
    output logic [IDX_W-1:0]  first_ch,
    output logic [7:0]        event_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_BLOCKED = 2'd2
    } ch_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

    logic [NUM_CH-1:0] stall;
    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] block_q, block_d;
    logic              any_block_q, any_block_d;
    logic              first_valid_q, first_valid_d;
    logic [IDX_W-1:0]  first_ch_q, first_ch_d;
    logic [7:0]        event_cnt_q, event_cnt_d;
    logic [IDX_W-1:0]  lowest_idx;
    logic              new_block;

    // Producer side stalls on valid without ready; consumer side on ready without valid.
    always_comb begin
        stall = (DIR_MASK & ch_valid & ~ch_ready) | (~DIR_MASK & ch_ready & ~ch_valid);
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!ch_enable[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (stall[i]) begin
                            if (THRESH == 1) begin
                                state_d[i] = ST_BLOCKED;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = ST_COUNT;
                                cnt_d[i]   = CNT_ONE;
                            end
                        end
                    end
                    ST_COUNT: begin
                        if (!stall[i]) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = ST_BLOCKED;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_BLOCKED: begin
                        if (!stall[i]) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            block_d[i] = (state_d[i] == ST_BLOCKED);
        end
    end

    // Descending scan so the lowest set index wins.
    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (block_d[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        any_block_d   = |block_d;
        new_block     = |(block_d & ~block_q);
        first_valid_d = first_valid_q;
        first_ch_d    = first_ch_q;
        event_cnt_d   = event_cnt_q;
        if (clear) begin
            first_valid_d = 1'b0;
            first_ch_d    = '0;
            event_cnt_d   = '0;
        end else begin
            if (!first_valid_q && any_block_d) begin
                first_valid_d = 1'b1;
                first_ch_d    = lowest_idx;
            end
            if (new_block && (event_cnt_q != 8'hFF)) begin
                event_cnt_d = event_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            block_q       <= '0;
            any_block_q   <= 1'b0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
            event_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            block_q       <= block_d;
            any_block_q   <= any_block_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
            event_cnt_q   <= event_cnt_d;
        end
    end

    assign axis_block_sigs = block_q;
    assign any_block       = any_block_q;
    assign first_valid     = first_valid_q;
    assign first_ch        = first_ch_q;
    assign event_cnt       = event_cnt_q;

endmodule

// File: tb/tb_foc_axis_block_detector.sv
// tb/tb_foc_axis_block_detector.sv - directed bench for foc_axis_block_detector
module tb_foc_axis_block_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] ch_valid, ch_ready, ch_enable;
    logic       clear;
    logic [9:0] axis_block_sigs;
    logic       any_block, first_valid;
    logic [3:0] first_ch;
    logic [7:0] event_cnt;

    int total = 0;
    int bad   = 0;

    // {axis_block_sigs, any_block, first_valid, first_ch, event_cnt}
    logic [23:0] obs;
    logic [23:0] exp;
    assign obs = {axis_block_sigs, any_block, first_valid, first_ch, event_cnt};

    foc_axis_block_detector #(
        .NUM_CH(10), .IDX_W(4), .CNT_W(16), .THRESH(4), .DIR_MASK(10'h001)
    ) dut (
        .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_enable(ch_enable), .clear(clear), .axis_block_sigs(axis_block_sigs),
        .any_block(any_block), .first_valid(first_valid), .first_ch(first_ch),
        .event_cnt(event_cnt)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_clear;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; clear = 1'b0;
        ch_valid = '0; ch_ready = '0; ch_enable = '1;
        step(2);
        exp = '0;
        total++; if (obs !== exp) begin bad++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
        reset = 1'b0;
        step(1);
        total++; if (obs !== exp) begin bad++; $display("FAIL post_reset_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_write_side;
        do_clear();
        ch_valid[0] = 1'b1; ch_ready[0] = 1'b0;
        step(3);
        exp = '0;
        total++; if (obs !== exp) begin bad++; $display("FAIL wr_before_thresh got=%h exp=%h", obs, exp); end
        step(1);
        exp = {10'h001, 1'b1, 1'b1, 4'd0, 8'd1};
        total++; if (obs !== exp) begin bad++; $display("FAIL wr_block got=%h exp=%h", obs, exp); end
        step(1);
        total++; if (obs !== exp) begin bad++; $display("FAIL wr_hold got=%h exp=%h", obs, exp); end
        ch_ready[0] = 1'b1;
        step(1);
        exp = {10'h000, 1'b0, 1'b1, 4'd0, 8'd1};
        total++; if (obs !== exp) begin bad++; $display("FAIL wr_release got=%h exp=%h", obs, exp); end
        ch_valid[0] = 1'b0; ch_ready[0] = 1'b0;
    endtask

    task automatic test_read_side_restart;
        do_clear();
        ch_ready[3] = 1'b1; ch_valid[3] = 1'b0;
        step(3);
        exp = '0;
        total++; if (obs !== exp) begin bad++; $display("FAIL rd_three got=%h exp=%h", obs, exp); end
        ch_valid[3] = 1'b1;
        step(1);
        total++; if (obs !== exp) begin bad++; $display("FAIL rd_handshake got=%h exp=%h", obs, exp); end
        ch_valid[3] = 1'b0;
        step(3);
        total++; if (obs !== exp) begin bad++; $display("FAIL rd_restart_three got=%h exp=%h", obs, exp); end
        step(1);
        exp = {10'h008, 1'b1, 1'b1, 4'd3, 8'd1};
        total++; if (obs !== exp) begin bad++; $display("FAIL rd_block got=%h exp=%h", obs, exp); end
        ch_ready[3] = 1'b0;
        step(1);
    endtask

    task automatic test_simultaneous;
        do_clear();
        ch_ready[5] = 1'b1; ch_ready[2] = 1'b1;
        step(4);
        exp = {10'h024, 1'b1, 1'b1, 4'd2, 8'd1};
        total++; if (obs !== exp) begin bad++; $display("FAIL simul_block got=%h exp=%h", obs, exp); end
        ch_ready[5] = 1'b0; ch_ready[2] = 1'b0;
        step(1);
    endtask

    task automatic test_clear_recapture;
        do_clear();
        ch_ready[7] = 1'b1;
        step(4);
        exp = {10'h080, 1'b1, 1'b1, 4'd7, 8'd1};
        total++; if (obs !== exp) begin bad++; $display("FAIL clr_block got=%h exp=%h", obs, exp); end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        exp = {10'h080, 1'b1, 1'b0, 4'd0, 8'd0};
        total++; if (obs !== exp) begin bad++; $display("FAIL clr_pulse got=%h exp=%h", obs, exp); end
        step(1);
        exp = {10'h080, 1'b1, 1'b1, 4'd7, 8'd0};
        total++; if (obs !== exp) begin bad++; $display("FAIL clr_recapture got=%h exp=%h", obs, exp); end
        ch_ready[7] = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_count;
        do_clear();
        ch_ready[1] = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp = '0;
        total++; if (obs !== exp) begin bad++; $display("FAIL rst_mid got=%h exp=%h", obs, exp); end
        step(3);
        total++; if (obs !== exp) begin bad++; $display("FAIL rst_three_after got=%h exp=%h", obs, exp); end
        step(1);
        exp = {10'h002, 1'b1, 1'b1, 4'd1, 8'd1};
        total++; if (obs !== exp) begin bad++; $display("FAIL rst_then_block got=%h exp=%h", obs, exp); end
        ch_ready[1] = 1'b0;
        step(1);
    endtask

    task automatic test_saturate_and_enable;
        do_clear();
        for (int ep = 0; ep < 300; ep++) begin
            ch_ready[4] = 1'b1;
            step(4);
            ch_ready[4] = 1'b0;
            step(1);
            if (ep == 99) begin
                exp = {10'h000, 1'b0, 1'b1, 4'd4, 8'd100};
                total++; if (obs !== exp) begin bad++; $display("FAIL sat_mid got=%h exp=%h", obs, exp); end
            end
        end
        exp = {10'h000, 1'b0, 1'b1, 4'd4, 8'd255};
        total++; if (obs !== exp) begin bad++; $display("FAIL sat_255 got=%h exp=%h", obs, exp); end
        ch_ready[4] = 1'b1;
        step(4);
        exp = {10'h010, 1'b1, 1'b1, 4'd4, 8'd255};
        total++; if (obs !== exp) begin bad++; $display("FAIL sat_hold got=%h exp=%h", obs, exp); end
        ch_enable[4] = 1'b0;
        step(1);
        exp = {10'h000, 1'b0, 1'b1, 4'd4, 8'd255};
        total++; if (obs !== exp) begin bad++; $display("FAIL en_drop got=%h exp=%h", obs, exp); end
        step(4);
        total++; if (obs !== exp) begin bad++; $display("FAIL en_override got=%h exp=%h", obs, exp); end
        ch_enable[4] = 1'b1; ch_ready[4] = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_write_side();
        test_read_side_restart();
        test_simultaneous();
        test_clear_recapture();
        test_reset_mid_count();
        test_saturate_and_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
